// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared definitions for the data-memory bridge.
//   state_t      - bridge FSM encoding (IDLE/REQ/WAIT/DONE)
//   TIMEOUT_FILL - read data returned to the core when a watchdog abort occurs
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bridge_wdt.sv
// mem_bridge_wdt: watchdog for the bridge (used only with MEM_BRIDGE_TIMEOUT_EN).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - pulse on the cycle the bridge enters REQ (clears the count)
//   active    - high while the bridge is in REQ or WAIT
//   expire    - high in the TIMEOUT-th cycle of REQ/WAIT; bridge aborts
//   err       - sticky timeout flag, cleared only by rst
module mem_bridge_wdt
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expire,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of REQ/WAIT cycles already completed, so the
  // abort lands exactly in the TIMEOUT-th cycle.
  assign expire = active && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (active && !expire)
        cnt <= cnt + CW'(1);
      if (expire)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: turns the core's single-cycle data access into a registered
// valid/ready request plus read-response handshake, stalling the core until
// the access completes. At most one access is in flight.
// Optional watchdog: define MEM_BRIDGE_TIMEOUT_EN to abort accesses that take
// TIMEOUT cycles in REQ/WAIT (reads return 32'hDEADBEEF, o_err sticks high).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   i_read_en, i_write_en    - core load/store request (write wins if both)
//   i_addr, i_wdata          - core address / store data
//   o_rdata                  - last captured load data
//   o_exstall                - stall to core (combinational)
//   o_bus_valid/we/addr/wdata, i_bus_ready - request channel
//   i_bus_rvalid, i_bus_rdata               - read response channel
//   o_err                    - sticky timeout flag (0 without the watchdog)
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read_en,
  input  logic          i_write_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_exstall,
  output logic          o_bus_valid,
  input  logic          i_bus_ready,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  input  logic          i_bus_rvalid,
  input  logic [DW-1:0] i_bus_rdata,
  output logic          o_err
);

  state_t state;
  logic   core_req;
  logic   expire;

  assign core_req  = i_read_en || i_write_en;
  assign o_exstall = ((state == ST_IDLE) && core_req) || (state == ST_REQ) || (state == ST_WAIT);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic wdt_start;
  logic wdt_active;

  assign wdt_start  = (state == ST_IDLE) && core_req;
  assign wdt_active = (state == ST_REQ) || (state == ST_WAIT);

  mem_bridge_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .start (wdt_start),
    .active(wdt_active),
    .expire(expire),
    .err   (o_err)
  );
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT;
  assign expire     = 1'b0;
  assign o_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      o_bus_valid <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (core_req) begin
            o_bus_we    <= i_write_en;
            o_bus_addr  <= i_addr;
            o_bus_wdata <= i_wdata;
            o_bus_valid <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Abort takes precedence so the sticky error always matches a real abort.
          if (expire) begin
            o_bus_valid <= 1'b0;
            if (!o_bus_we)
              o_rdata <= DW'(TIMEOUT_FILL);
            state <= ST_DONE;
          end else if (i_bus_ready) begin
            o_bus_valid <= 1'b0;
            state       <= o_bus_we ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (expire) begin
            o_rdata <= DW'(TIMEOUT_FILL);
            state   <= ST_DONE;
          end else if (i_bus_rvalid) begin
            o_rdata <= i_bus_rdata;
            state   <= ST_DONE;
          end
        end
        // The core's access is still present here; ignoring it avoids a re-issue.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: self-checking bench for mem_bridge. Table-driven accesses,
// randomized accesses against a transaction-level model, and hand-written
// sequences for reset during WAIT and (with MEM_BRIDGE_TIMEOUT_EN) the watchdog.
module tb_mem_bridge;

  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int CYCLE_LIMIT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read_en, i_write_en;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] o_rdata;
  logic          o_exstall;
  logic          o_bus_valid;
  logic          i_bus_ready;
  logic          o_bus_we;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_rvalid;
  logic [DW-1:0] i_bus_rdata;
  logic          o_err;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int exp_hs   = 0;

  logic [DW-1:0] model_rdata;

  mem_bridge #(
    .AW(AW), .DW(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_write_en(i_write_en),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_exstall(o_exstall),
    .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && o_bus_valid && i_bus_ready)
      hs_count <= hs_count + 1;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rdly;
    int            vdly;
    logic [DW-1:0] rdata;
    int            exp_stall;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One core access with a responder that raises ready after rdly valid
  // cycles and rvalid after vdly waiting cycles. Called with the DUT in IDLE
  // (#1 after a rising edge); returns #1 after the edge that leaves DONE.
  task automatic do_access(input logic wr, input logic rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int rdly, input int vdly,
                           input logic [DW-1:0] rdata,
                           output int stall, output int vcyc, output int reqs,
                           output bit bus_ok, output bit done_seen,
                           output logic [DW-1:0] rdata_done);
    int vcnt, wcnt;
    bit pending;
    stall = 0; vcyc = 0; reqs = 0; bus_ok = 1'b1; done_seen = 1'b0;
    vcnt = 0; wcnt = 0; pending = 1'b0; rdata_done = '0;
    i_write_en = wr; i_read_en = rd; i_addr = addr; i_wdata = wdata;
    for (int c = 0; c < CYCLE_LIMIT && !done_seen; c++) begin
      i_bus_ready = o_bus_valid && (vcnt >= rdly);
      if (pending) begin
        i_bus_rvalid = (wcnt >= vdly);
        i_bus_rdata  = rdata;
      end else begin
        // Stray responses outside WAIT must be ignored by the bridge.
        i_bus_rvalid = 1'($urandom_range(0, 1));
        i_bus_rdata  = $urandom;
      end
      @(negedge clk);
      if (o_exstall) stall++;
      else if (stall > 0) begin
        done_seen  = 1'b1;
        rdata_done = o_rdata;
      end
      if (o_bus_valid) begin
        vcyc++;
        if (o_bus_we !== wr || o_bus_addr !== addr || (wr && o_bus_wdata !== wdata))
          bus_ok = 1'b0;
        if (i_bus_ready) begin
          reqs++;
          if (!wr) begin pending = 1'b1; wcnt = 0; end
        end else vcnt++;
      end else if (pending) begin
        if (i_bus_rvalid) pending = 1'b0;
        else wcnt++;
      end
      @(posedge clk); #1;
    end
    i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
  endtask

  task automatic run_checked(input string tag, input logic wr, input logic rd,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input int rdly, input int vdly, input logic [DW-1:0] rdata,
                             input int exp_stall, input int exp_vcyc, input logic [DW-1:0] exp_rdata,
                             input logic exp_err);
    int stall, vcyc, reqs;
    bit bus_ok, done_seen;
    logic [DW-1:0] rdata_done;
    do_access(wr, rd, addr, wdata, rdly, vdly, rdata, stall, vcyc, reqs, bus_ok, done_seen, rdata_done);
    exp_hs++;
    check({tag, " done"}, 64'(done_seen), 64'd1);
    check({tag, " stall"}, 64'(stall), 64'(exp_stall));
    check({tag, " reqs"}, 64'(reqs), 64'(exp_vcyc > 0 ? 1 : 0));
    check({tag, " valid_cycles"}, 64'(vcyc), 64'(exp_vcyc));
    check({tag, " bus_fields"}, 64'(bus_ok), 64'd1);
    check({tag, " rdata"}, 64'(rdata_done), 64'(exp_rdata));
    check({tag, " err"}, 64'(o_err), 64'(exp_err));
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1;
    i_read_en = 1'b0; i_write_en = 1'b0; i_addr = '0; i_wdata = '0;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
    model_rdata = '0;

    //            wr    rd    addr           wdata          rdly vdly rdata          stall exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         0,   0,   32'hCAFE_F00D, 3,    32'hCAFE_F00D};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 3,   0,   32'h0,         5,    32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 1,   0,   32'h1111_1111, 3,    32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0404, 32'h0,         2,   3,   32'h0BAD_F00D, 8,    32'h0BAD_F00D};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 0,   0,   32'h0,         2,    32'h0BAD_F00D};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         0,   5,   32'h0000_0000, 8,    32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset bus_valid", 64'(o_bus_valid), 64'd0);
    check("reset bus_we", 64'(o_bus_we), 64'd0);
    check("reset bus_addr", 64'(o_bus_addr), 64'd0);
    check("reset bus_wdata", 64'(o_bus_wdata), 64'd0);
    check("reset rdata", 64'(o_rdata), 64'd0);
    check("reset err", 64'(o_err), 64'd0);
    check("reset exstall", 64'(o_exstall), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: run back to back, core inputs held through each DONE.
    foreach (vecs[i]) begin
      run_checked($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                  vecs[i].rdly, vecs[i].vdly, vecs[i].rdata,
                  vecs[i].exp_stall, vecs[i].rdly + 1, vecs[i].exp_rdata, 1'b0);
    end
    model_rdata = 32'h0000_0000;

    i_read_en = 1'b0; i_write_en = 1'b0;
    @(negedge clk);
    check("idle exstall", 64'(o_exstall), 64'd0);
    check("idle bus_valid", 64'(o_bus_valid), 64'd0);
    @(posedge clk); #1;

    // Randomized accesses against a transaction-level model.
    for (int n = 0; n < 40; n++) begin
      logic wr, rd;
      int rdly, vdly, exp_stall;
      logic [DW-1:0] rdata;
      wr    = 1'($urandom_range(0, 1));
      rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rdly  = $urandom_range(0, 3);
      vdly  = $urandom_range(0, 3);
      rdata = $urandom;
      exp_stall = 1 + (rdly + 1) + (wr ? 0 : vdly + 1);
      if (!wr) model_rdata = rdata;
      run_checked($sformatf("rand%0d", n), wr, rd, $urandom, $urandom, rdly, vdly, rdata,
                  exp_stall, rdly + 1, model_rdata, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        i_read_en = 1'b0; i_write_en = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Reset asserted while waiting for read data.
    i_read_en = 1'b1; i_write_en = 1'b0; i_addr = 32'h0000_0055;
    @(posedge clk); #1;
    i_bus_ready = 1'b1;
    @(posedge clk); #1;
    exp_hs++;
    i_bus_ready = 1'b0;
    @(negedge clk);
    check("wait exstall", 64'(o_exstall), 64'd1);
    check("wait bus_valid", 64'(o_bus_valid), 64'd0);
    #2;
    rst = 1'b1; i_read_en = 1'b0;
    #1;
    check("midrst bus_valid", 64'(o_bus_valid), 64'd0);
    check("midrst exstall", 64'(o_exstall), 64'd0);
    check("midrst rdata", 64'(o_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h7777_7777;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("late rvalid rdata", 64'(o_rdata), 64'd0);
    check("late rvalid exstall", 64'(o_exstall), 64'd0);
    check("late rvalid bus_valid", 64'(o_bus_valid), 64'd0);
    i_bus_rvalid = 1'b0;
    @(posedge clk); #1;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Read accepted but never answered: abort in the 8th REQ/WAIT cycle.
    run_checked("timeout read", 1'b0, 1'b1, 32'h0000_0900, 32'h0, 0, 1000, 32'h0,
                9, 1, 32'hDEADBEEF, 1'b1);
    i_read_en = 1'b0;
    @(posedge clk); #1;
    run_checked("after timeout", 1'b1, 1'b0, 32'h0000_0A00, 32'h0000_0042, 0, 0, 32'h0,
                2, 1, 32'hDEADBEEF, 1'b1);
    i_write_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("err cleared by rst", 64'(o_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`endif

    check("total bus requests", 64'(hs_count), 64'(exp_hs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
